sfx_sample_player: RTL and testbench

Upstream feeder for the speaker PWM stage: plays one of `NUM_SFX` 8-bit unsigned sound-effect clips from a synchronous sample ROM, one sample per sample-rate tick, and drives the 8-bit `Sound` input of the PWM/counter block. Game logic issues one-cycle play/stop requests. The player handles clip sequencing, looping, retrigger and ROM latency. When no clip is playing, it emits mid-scale silence at the same rate.

---
 rtl/sfx_sample_player.sv | 139 +++++++++++++
 tb/tb_sfx_sample_player.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sample_player.sv
// Sound-effect clip player: steps through a clip in a synchronous sample ROM,
// one sample per sample_tick, and emits mid-scale silence when idle.
module sfx_sample_player #(
  parameter int                        ADDR_W    = 16,
  parameter int                        NUM_SFX   = 4,
  parameter logic [NUM_SFX*ADDR_W-1:0] CLIP_BASE = '0,
  parameter logic [NUM_SFX*ADDR_W-1:0] CLIP_LEN  = '0,
  parameter logic [7:0]                SILENCE   = 8'h80,
  localparam int                       ID_W      = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              play_req,
  input  logic [ID_W-1:0]   play_id,
  input  logic              loop,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  // state | meaning
  // IDLE  | no clip; each tick emits SILENCE
  // ARMED | clip active, waiting for the next tick
  // FETCH | rom_addr issued, ROM data arrives next cycle
  // LATCH | rom_data valid, capture sample and advance
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] remaining;
  logic              loop_r;
  logic [ID_W-1:0]   id_r;
  logic              in_flight;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_len;

  // Ids with no table entry fall through to length 0 and behave as empty clips.
  function automatic logic [ADDR_W-1:0] base_of(input logic [ID_W-1:0] id);
    base_of = '0;
    for (int i = 0; i < NUM_SFX; i++)
      if (id == i[ID_W-1:0]) base_of = CLIP_BASE[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] len_of(input logic [ID_W-1:0] id);
    len_of = '0;
    for (int i = 0; i < NUM_SFX; i++)
      if (id == i[ID_W-1:0]) len_of = CLIP_LEN[i*ADDR_W +: ADDR_W];
  endfunction

  assign in_flight = (state == FETCH) || (state == LATCH);
  assign req_base  = base_of(play_id);
  assign req_len   = len_of(play_id);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      sample_out   <= SILENCE;
      rom_addr     <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      cur_addr     <= '0;
      remaining    <= '0;
      loop_r       <= 1'b0;
      id_r         <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;

      if ((state == IDLE) && sample_tick) begin
        sample_out   <= SILENCE;
        sample_valid <= 1'b1;
      end

      if (sample_tick && in_flight) overrun <= 1'b1;

      // Requests take priority over the sequencer; stop beats play.
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (play_req) begin
        id_r      <= play_id;
        loop_r    <= loop;
        cur_addr  <= req_base;
        remaining <= req_len;
        overrun   <= 1'b0;
        if (req_len == '0) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ARMED;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          ARMED: begin
            if (sample_tick) begin
              rom_addr <= cur_addr;
              state    <= FETCH;
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            sample_out   <= rom_data;
            sample_valid <= 1'b1;
            cur_addr     <= cur_addr + 1'b1;
            remaining    <= remaining - 1'b1;
            if (remaining == ADDR_W'(1)) begin
              if (loop_r) begin
                cur_addr  <= base_of(id_r);
                remaining <= len_of(id_r);
                state     <= ARMED;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state <= ARMED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sfx_sample_player.sv
// Bench for sfx_sample_player: directed scenarios then random play/stop/tick
// traffic, checked against an event-level model of clip playback.
module tb_sfx_sample_player;

  localparam int ADDR_W = 16;
  localparam int NUM_SFX = 4;
  localparam logic [NUM_SFX*ADDR_W-1:0] CLIP_BASE = {16'h0000, 16'h0200, 16'h0100, 16'hFFFE};
  localparam logic [NUM_SFX*ADDR_W-1:0] CLIP_LEN  = {16'd0, 16'd4, 16'd3, 16'd5};

  logic              Clk = 1'b0;
  logic              reset = 1'b0;
  logic              sample_tick = 1'b0;
  logic              play_req = 1'b0;
  logic [1:0]        play_id = 2'd0;
  logic              loop = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data = 8'h00;
  logic [7:0]        sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;
  logic              overrun;

  sfx_sample_player #(
    .ADDR_W(ADDR_W), .NUM_SFX(NUM_SFX), .CLIP_BASE(CLIP_BASE),
    .CLIP_LEN(CLIP_LEN), .SILENCE(8'h80)
  ) dut (
    .Clk(Clk), .reset(reset), .sample_tick(sample_tick), .play_req(play_req),
    .play_id(play_id), .loop(loop), .stop(stop), .rom_addr(rom_addr),
    .rom_data(rom_data), .sample_out(sample_out), .sample_valid(sample_valid),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  // Sample ROM: contents are the low address byte, one cycle of latency.
  always @(posedge Clk) rom_data <= rom_addr[7:0];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       cyc;
    bit       v;
    bit       d;
    bit [7:0] s;
    bit       p;
  } ev_t;
  ev_t q[$];

  int m_base[4] = '{32'hFFFE, 32'h0100, 32'h0200, 32'h0000};
  int m_len[4]  = '{5, 3, 4, 0};
  int m_id = 0;
  int m_pos = 0;
  int m_fetch_end = -1;
  bit m_playing = 0;
  bit m_loop = 0;
  bit m_overrun = 0;

  function automatic void push_ev(ev_t e);
    int i = q.size();
    while (i > 0 && q[i-1].cyc > e.cyc) i--;
    q.insert(i, e);
  endfunction

  function automatic void drop_after(int c);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].p && q[i].cyc > c) q.delete(i);
  endfunction

  // Expected behaviour at the clip level: a request or tick in cycle c
  // schedules output events; a tick during an outstanding fetch is lost.
  function automatic void model(int c, bit tk, bit pr, int id, bit lp, bit sp);
    ev_t e;
    int addr;
    if (sp) begin
      m_playing = 0;
      m_fetch_end = -1;
      drop_after(c);
    end else if (pr) begin
      m_overrun = 0;
      m_fetch_end = -1;
      drop_after(c);
      m_id = id;
      m_loop = lp;
      m_pos = 0;
      m_playing = (m_len[id] != 0);
      if (!m_playing) begin
        e = '{cyc: c + 1, v: 1'b0, d: 1'b1, s: 8'h00, p: 1'b1};
        push_ev(e);
      end
    end
    if (tk) begin
      if (c <= m_fetch_end) begin
        m_overrun = 1;
      end else if (!m_playing) begin
        e = '{cyc: c + 1, v: 1'b1, d: 1'b0, s: 8'h80, p: 1'b0};
        push_ev(e);
      end else begin
        addr = (m_base[m_id] + m_pos) % 65536;
        e = '{cyc: c + 3, v: 1'b1, d: (m_pos == m_len[m_id] - 1) && !m_loop,
              s: 8'(addr % 256), p: 1'b1};
        push_ev(e);
        m_fetch_end = c + 2;
        m_pos++;
        if (m_pos == m_len[m_id]) begin
          m_pos = 0;
          if (!m_loop) m_playing = 0;
        end
      end
    end
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(bit tk, bit pr, int id, bit lp, bit sp);
    @(posedge Clk); #1;
    chk("busy", 16'(busy), 16'(m_playing || (cyc <= m_fetch_end)));
    chk("overrun", 16'(overrun), 16'(m_overrun));
    sample_tick = tk;
    play_req = pr;
    play_id = 2'(id);
    loop = lp;
    stop = sp;
    model(cyc, tk, pr, id, lp, sp);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic tick_gap(int gap);
    step(1, 0, 0, 0, 0);
    idle(gap - 1);
  endtask

  task automatic play(int id, bit lp);
    step(0, 1, id, lp, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_sample_out", 16'(sample_out), 16'h0080);
    chk("rst_rom_addr", rom_addr, 16'h0000);
    chk("rst_valid", 16'(sample_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
  endtask

  // Output monitor: valid/done must appear exactly in the scheduled cycles.
  ev_t mon_e;
  bit  mon_hit;
  always @(negedge Clk) begin
    if (reset) begin
      mon_hit = 0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        mon_e = q.pop_front();
        checks++;
        errors++;
        $error("FAIL missed_event cyc=%0d got=none exp=%0h", mon_e.cyc, mon_e.s);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        mon_hit = 1;
      end else begin
        mon_e = '{cyc: cyc, v: 1'b0, d: 1'b0, s: 8'h00, p: 1'b0};
      end
      if (mon_hit || sample_valid || done) begin
        checks++;
        assert (sample_valid === mon_e.v && done === mon_e.d) else begin
          errors++;
          $error("FAIL valid_done cyc=%0d got=%b%b exp=%b%b", cyc, sample_valid, done, mon_e.v, mon_e.d);
        end
        if (mon_e.v) begin
          checks++;
          assert (sample_out === mon_e.s) else begin
            errors++;
            $error("FAIL sample cyc=%0d got=%0h exp=%0h", cyc, sample_out, mon_e.s);
          end
        end
      end
    end
  end

  initial begin
    int gap;
    int k;
    int act;
    repeat (3) @(posedge Clk);
    #1;
    chk_reset_vals();
    reset = 1'b1;

    // Idle silence, one valid per tick
    repeat (4) tick_gap(8);

    // Single-shot clip 1: 00, 01, 02 with done on the last, then silence
    play(1, 0);
    idle(2);
    repeat (4) tick_gap(8);

    // Looping clip 1, then stop mid-clip
    play(1, 1);
    idle(2);
    repeat (7) tick_gap(5);
    step(0, 0, 0, 0, 1);
    idle(2);
    tick_gap(8);

    // Retrigger to clip 2 during the fetch of clip 1's second sample
    play(1, 0);
    idle(2);
    tick_gap(8);
    step(1, 0, 0, 0, 0);
    play(2, 0);
    idle(3);
    tick_gap(8);
    step(0, 0, 0, 0, 1);
    idle(2);

    // stop beats play; zero-length clip gives done only
    step(0, 1, 1, 0, 1);
    idle(3);
    tick_gap(8);
    play(3, 0);
    idle(3);
    tick_gap(8);

    // Wrapping clip 0 (FFFE..0002)
    play(0, 0);
    idle(2);
    repeat (6) tick_gap(4);

    // Tick landing in LATCH is dropped and flags overrun
    play(1, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(5);
    repeat (3) tick_gap(8);

    // Asynchronous reset while a fetch is in flight
    play(1, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    q.delete();
    m_playing = 0;
    m_fetch_end = -1;
    m_overrun = 0;
    @(posedge Clk); #1;
    reset = 1'b1;
    idle(2);
    tick_gap(8);

    // Random traffic with requests at random offsets inside each tick gap
    for (int n = 0; n < 150; n++) begin
      gap = $urandom_range(2, 7);
      k = $urandom_range(1, gap);
      act = $urandom_range(0, 9);
      step(1, 0, 0, 0, 0);
      for (int j = 1; j <= gap; j++) begin
        if (j == k && act < 3)
          play($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        else if (j == k && act == 3)
          step(0, 0, 0, 0, 1);
        else
          idle(1);
      end
    end

    step(0, 0, 0, 0, 1);
    idle(10);
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
